// File: rtl/io_port_pkg.sv
// Shared types and helpers for the IN/OUT port responder and its output FIFO.
package io_port_pkg;

  localparam int IO_DATA_W = 8;

  typedef enum logic {
    IN_EMPTY = 1'b0,
    IN_FULL  = 1'b1
  } in_state_e;

  // Smallest w with 2**w >= value; used for pointer widths.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/io_out_fifo.sv
// Power-of-two deep FIFO with registered count; reusable for other byte-stream producers.
module io_out_fifo
  import io_port_pkg::*;
#(
  parameter int OUT_DEPTH = 4,
  parameter int DATA_W    = IO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(OUT_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/io_port_responder.sv
// CPU IN/OUT port responder: OUT bytes queue to the device, IN bytes land in a one-entry buffer.
// Optional interrupt on IN capture is enabled with `define IO_PORT_IRQ_EN.
module io_port_responder
  import io_port_pkg::*;
#(
  parameter int OUT_DEPTH = 4,
  parameter int DATA_W    = IO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_wr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_rd,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_stall,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
`ifdef IO_PORT_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_ack
`endif
);

  in_state_e         in_state_q;
  logic [DATA_W-1:0] in_buf_q;
  logic              fifo_full, fifo_empty;
  logic              fifo_pop;
  logic              rd_take;
  logic              capture;

  assign fifo_pop = out_valid && out_ready;

  // The FIFO itself refuses a push when full, so io_wr can feed it directly.
  io_out_fifo #(
    .OUT_DEPTH(OUT_DEPTH),
    .DATA_W   (DATA_W)
  ) u_out_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (io_wr),
    .wdata_i(io_wdata),
    .pop_i  (fifo_pop),
    .rdata_o(out_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign out_valid = !fifo_empty;

  // A simultaneous write wins; the read is ignored and does not drain the buffer.
  assign rd_take  = io_rd && !io_wr && (in_state_q == IN_FULL);
  assign capture  = (in_state_q == IN_EMPTY) && in_valid;
  assign io_rdata = rd_take ? in_buf_q : '0;
  assign io_stall = io_wr ? fifo_full : (io_rd && (in_state_q == IN_EMPTY));
  assign in_ready = (in_state_q == IN_EMPTY) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_q <= IN_EMPTY;
      in_buf_q   <= '0;
    end else begin
      case (in_state_q)
        IN_EMPTY: begin
          if (in_valid) begin
            in_buf_q   <= in_data;
            in_state_q <= IN_FULL;
          end
        end
        IN_FULL: begin
          if (rd_take) in_state_q <= IN_EMPTY;
        end
        default: in_state_q <= IN_EMPTY;
      endcase
    end
  end

`ifdef IO_PORT_IRQ_EN
  logic irq_q;

  // Clearing beats setting when an ack or drain coincides with a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (irq_ack || rd_take) begin
      irq_q <= 1'b0;
    end else if (capture) begin
      irq_q <= 1'b1;
    end
  end

  assign irq = irq_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule
